// File: rtl/text_console_if.sv
// Byte-stream handshake into the text console: producer drives data/valid,
// the console answers with ready.
interface text_console_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/text_console.sv
// Character-cell text buffer feeding the glyph ROM. Bytes arriving on the
// handshake are printed or interpreted as control codes. The screen is held in
// a COLS x ROWS RAM whose row origin (top_row) rotates for hardware scrolling.
// The read side registers the cell code under the current pixel position.
//
// state  | meaning
// -------+-----------------------------------------------------------
// CLEAR  | write BLANK to every cell, one per cycle, then go to IDLE
// IDLE   | in_ready high, accept and act on one byte per cycle
// SCROLL | write BLANK across the physical row that just became the bottom
module text_console #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter int         FONT_WIDTH = 8,
  parameter logic [7:0] BLANK      = 8'h20
) (
  input  logic                    px_clk,
  input  logic                    resetn,
  input  logic [9:0]              pos_x,
  input  logic [9:0]              pos_y,
  text_console_if.slave           bus,
  output logic [FONT_WIDTH-1:0]   character,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  cnt, cnt_nx;
  logic [CW-1:0]  col_nx;
  logic [RW-1:0]  row_nx;
  logic [RW-1:0]  top_row, top_nx;
  logic [RW-1:0]  scroll_row, scroll_nx;
  logic           accept;
  logic           do_nl;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;
  logic [7:0]     mem [CELLS];
  logic           rd_on;
  logic [AW-1:0]  rd_addr;
  logic           unused_px;

  // Screen row to physical RAM row under the current scroll origin.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r,
                                             input logic [RW-1:0] top);
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                              input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign accept    = bus.in_valid && bus.in_ready;
  assign unused_px = ^{pos_x[2:0], pos_y[2:0]};

  // State, counter, cursor and scroll origin registers; ready mirrors IDLE.
  always_ff @(posedge px_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_CLEAR;
      cnt          <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      top_row      <= '0;
      scroll_row   <= '0;
      bus.in_ready <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      cursor_col   <= col_nx;
      cursor_row   <= row_nx;
      top_row      <= top_nx;
      scroll_row   <= scroll_nx;
      bus.in_ready <= (state_nx == ST_IDLE);
    end
  end

  // Next state: sequence clears/scrolls and interpret accepted bytes.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    col_nx    = cursor_col;
    row_nx    = cursor_row;
    top_nx    = top_row;
    scroll_nx = scroll_row;
    do_nl     = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (cnt == AW'(CELLS - 1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_SCROLL: begin
        if (cnt == AW'(COLS - 1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (bus.in_data)
            8'h0D: col_nx = '0;
            8'h0A: do_nl = 1'b1;
            8'h08: if (cursor_col != '0) col_nx = cursor_col - 1'b1;
            8'h0C: begin
              top_nx   = '0;
              col_nx   = '0;
              row_nx   = '0;
              state_nx = ST_CLEAR;
              cnt_nx   = '0;
            end
            default: begin
              if (bus.in_data >= 8'h20) begin
                if (cursor_col == CW'(COLS - 1)) begin
                  col_nx = '0;
                  do_nl  = 1'b1;
                end else begin
                  col_nx = cursor_col + 1'b1;
                end
              end
            end
          endcase
          if (do_nl) begin
            if (cursor_row != RW'(ROWS - 1)) begin
              row_nx = cursor_row + 1'b1;
            end else begin
              // Old top row becomes the new bottom row and must be blanked.
              top_nx    = (top_row == RW'(ROWS - 1)) ? '0 : top_row + 1'b1;
              scroll_nx = top_row;
              state_nx  = ST_SCROLL;
              cnt_nx    = '0;
            end
          end
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  // Write port control: clear/scroll sweeps or the printable byte at the cursor.
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = BLANK;
    case (state)
      ST_CLEAR:  we = 1'b1;
      ST_SCROLL: begin
        we    = 1'b1;
        waddr = cell_addr(scroll_row, CW'(cnt));
      end
      ST_IDLE: begin
        if (accept && bus.in_data >= 8'h20) begin
          we    = 1'b1;
          waddr = cell_addr(phys_row(cursor_row, top_row), cursor_col);
          wdata = bus.in_data;
        end
      end
      default: we = 1'b0;
    endcase
  end

  // Cell RAM write port; contents are initialised by the CLEAR sweep.
  always_ff @(posedge px_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_on   = (pos_x[9:3] < 7'(COLS)) && (pos_y[9:3] < 7'(ROWS));
  assign rd_addr = cell_addr(phys_row(rd_on ? pos_y[RW+2:3] : '0, top_row),
                             rd_on ? pos_x[CW+2:3] : '0);

  // Registered read of the cell under the pixel position, blank off-screen.
  always_ff @(posedge px_clk or negedge resetn) begin
    if (!resetn) character <= BLANK[FONT_WIDTH-1:0];
    else         character <= rd_on ? mem[rd_addr][FONT_WIDTH-1:0]
                                    : BLANK[FONT_WIDTH-1:0];
  end
endmodule

// File: doc/text_console.md
# text_console

Character-cell text buffer directly upstream of the 8x8 glyph ROM stage. It accepts a byte stream over a valid/ready handshake and interprets printable bytes and a small set of control codes. It stores cell codes in a COLS x ROWS dual-port RAM with hardware scrolling. On the read side it maps the current screen position to a registered character code that drives the glyph ROM's `character` input.

## Interface
- `COLS`, 80: text columns (640 px / 8).
- `ROWS`, 60: text rows (480 px / 8).
- `BLANK`, 8'h20: code written by clear and scroll, and returned off-screen.
- `px_clk` in 1: pixel clock; the only clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `pos_x` in 10: screen X; column = `pos_x[9:3]`.
- `pos_y` in 10: screen Y; row = `pos_y[9:3]`.
- `in_data` in 8: byte to print or control code.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted on a clock edge where `in_valid && in_ready`.
- `character` out `FONT_WIDTH`: registered cell code, low `FONT_WIDTH` bits of the stored byte.
- `cursor_col` out $clog2(COLS): current write column.
- `cursor_row` out $clog2(ROWS): current write row, on-screen.

## Operation
- Storage is COLS*ROWS cells with one write port and one read port.
  - Physical address = phys_row*COLS + col.
  - phys_row = (screen_row + top_row) mod ROWS.
  - `top_row` is internal, reset 0.
- FSM states:
  - CLEAR: writes BLANK to cell k on cycle k, for k = 0..COLS*ROWS-1, then goes to IDLE.
  - IDLE: `in_ready`=1.
  - SCROLL: writes BLANK to the COLS cells of one physical row, then goes to IDLE.
- `in_ready` = (state == IDLE), registered.
- Accepted byte actions (all in IDLE):
  - 0x0D CR: col=0.
  - 0x0A LF: newline.
  - 0x08 BS: if col>0 then col-1; the cell is not erased.
  - 0x0C FF: top_row=0, cursor=(0,0), enter CLEAR.
  - Any other byte < 0x20: consumed, ignored.
  - Any byte >= 0x20: write to the cursor cell in the accept cycle. Then col+1; if col was COLS-1, col=0 and newline.
- Newline:
  - If row < ROWS-1: row+1.
  - Else: row stays ROWS-1, top_row=(top_row+1) mod ROWS, enter SCROLL clearing physical row old top_row (the new bottom screen row).
- Read path:
  - Each cycle, samples `pos_x`/`pos_y` and registers the stored cell code to `character`.
  - If column >= COLS or row >= ROWS, `character`=BLANK.
- Read and write to the same cell in the same cycle: either old or new value is acceptable.
- The read path runs in every state, so partial clears are visible.

## Timing
- Reset (asynchronous, `resetn`=0):
  - `in_ready`=0, cursor=(0,0), top_row=0, `character`=BLANK, state=CLEAR with counter 0.
  - RAM contents are not reset; the CLEAR sequence initialises them.
- After `resetn` rises: CLEAR takes exactly COLS*ROWS cycles (4800), then `in_ready`=1 on the next edge.
- Reset asserted mid-CLEAR or mid-SCROLL: takes effect immediately, the operation is aborted, and the full CLEAR restarts after release.
- Read latency: `character` reflects `pos_x`/`pos_y` one edge after sampling. Downstream glyph ROM adds one more; the pixel pipeline compensates for 2 cycles total.
- Write visibility: a byte accepted at edge N is readable by a position sampled at edge N+1.
- Cursor outputs update at the accept edge.
- FF: `in_ready` falls at the accept edge and is low for COLS*ROWS cycles.
- Scroll: `in_ready` falls at the edge accepting LF, or the wrapping printable byte, on the last row. It is low for COLS cycles (80).
- Only one byte is accepted per cycle. `in_data` is ignored while `in_ready`=0.

## Test plan
- Reset release → `in_ready`=0 for exactly 4800 cycles then 1; scan of all positions returns 0x20; cursor=(0,0).
- Send 0x41 → cursor_col=1; pos (0,0) gives `character`=0x41 one cycle after presentation; pos (8,0) gives 0x20.
- Send 80 × 0x42 → screen row 0 all 0x42, cursor=(0,1). Then send 0x08 at col 0 → cursor unchanged.
- Fill rows 0..59 with distinct codes 0x30+row using CR/LF, then send LF on row 59 → `in_ready` low 80 cycles.
  - Screen row 0 reads 0x31, row 58 reads 0x30+59, row 59 reads 0x20.
  - Cursor=(0,59).
- Send 0x0C mid-screen → `in_ready` low 4800 cycles, all cells 0x20, cursor=(0,0). Then pos_x=640 or pos_y=480 → 0x20.
- Pulse `resetn` low during SCROLL → `in_ready`=0 and cursor=(0,0) immediately; full 4800-cycle CLEAR follows release.
